// File: rtl/core_defs_pkg.sv
// Shared core definitions: datapath width, register address width, load funct3
// encodings and the load byte-shift helper.
package core_defs;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Right-shift amount that brings the addressed element down to bit 0.
  function automatic logic [5:0] load_shamt(input logic [2:0] f3, input logic [2:0] off);
    logic [5:0] sh;
    case (f3)
      F3_LB, F3_LBU: sh = {off, 3'b000};
      F3_LH, F3_LHU: sh = {off[2:1], 4'b0000};
      F3_LW, F3_LWU: sh = {off[2], 5'b00000};
      default:       sh = 6'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load extractor: selects the addressed byte/half/word from the raw
// doubleword and sign- or zero-extends it to XLEN.
module wb_load_ext
  import core_defs::*;
#(
  parameter int unsigned XLEN = core_defs::XLEN
) (
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_off,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_sh;

  assign w_sh = i_raw >> load_shamt(i_funct3, i_off);

  always_comb begin
    o_data = w_sh;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_sh[7]}},   w_sh[7:0]};
      F3_LH:   o_data = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
      F3_LW:   o_data = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}},      w_sh[7:0]};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}},     w_sh[15:0]};
      F3_LWU:  o_data = {{(XLEN-32){1'b0}},     w_sh[31:0]};
      default: o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and queued load returns onto one register-file
// write port, keeping write-after-write order per register. Optional: WB_RETIRE_CNT_EN.
module wb_arbiter
  import core_defs::*;
#(
  parameter int unsigned XLEN  = core_defs::XLEN,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_raw,
  input  logic [2:0]        ld_funct3,
  input  logic [2:0]        ld_off,
  output logic              ld_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_wd,
  output logic              busy
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [REG_AW-1:0] r_q_rd   [DEPTH];
  logic [XLEN-1:0]   r_q_data [DEPTH];
  logic [DEPTH-1:0]  r_q_vld;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              r_rf_we;
  logic [REG_AW-1:0] r_rf_a3;
  logic [XLEN-1:0]   r_rf_wd;

  logic [XLEN-1:0]   w_ext;
  logic              w_full;
  logic              w_empty;
  logic              w_alu_zero;
  logic              w_conflict;
  logic              w_alu_wr;
  logic              w_push;
  logic              w_pop;

  wb_load_ext #(.XLEN(XLEN)) u_ext (
    .i_raw    (ld_raw),
    .i_funct3 (ld_funct3),
    .i_off    (ld_off),
    .o_data   (w_ext)
  );

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_alu_zero = (alu_rd == '0);

  // An ALU write must not overtake an older queued load to the same register.
  always_comb begin
    w_conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_q_vld[PW'(i)] && (r_q_rd[PW'(i)] == alu_rd)) w_conflict = 1'b1;
    end
    if (w_alu_zero) w_conflict = 1'b0;
  end

  // x0 results never touch the write port, so they are taken without waiting.
  assign w_alu_wr  = alu_valid && !w_alu_zero && !w_full && !w_conflict;
  assign alu_ready = alu_valid && (w_alu_zero || (!w_full && !w_conflict));
  assign ld_ready  = !w_full;
  assign w_push    = ld_valid && !w_full && (ld_rd != '0);
  assign w_pop     = !w_empty && !w_alu_wr;
  assign busy      = !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_q_vld <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)  r_q_vld[r_rptr] <= 1'b0;
      if (w_push) r_q_vld[r_wptr] <= 1'b1;
    end
  end

  // Payload storage needs no reset; r_q_vld qualifies every entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= ld_rd;
      r_q_data[r_wptr] <= w_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we <= 1'b0;
      r_rf_a3 <= '0;
      r_rf_wd <= '0;
    end else begin
      r_rf_we <= w_alu_wr || w_pop;
      if (w_alu_wr) begin
        r_rf_a3 <= alu_rd;
        r_rf_wd <= alu_data;
      end else if (w_pop) begin
        r_rf_a3 <= r_q_rd[r_rptr];
        r_rf_wd <= r_q_data[r_rptr];
      end
    end
  end

  assign rf_we = r_rf_we;
  assign rf_a3 = r_rf_a3;
  assign rf_wd = r_rf_wd;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_retire_cnt <= '0;
    else     r_retire_cnt <= r_retire_cnt + 64'(r_rf_we);
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, ALU path, load extraction,
// queue-full stall, WAW conflict stall, x0 drops and mid-operation reset.
module tb_wb_arbiter;
  import core_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [63:0] ld_raw;
  logic [2:0]  ld_funct3;
  logic [2:0]  ld_off;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [63:0] rf_wd;
  logic        busy;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] raw;
    logic [63:0] exp;
  } ld_vec_t;

  ld_vec_t vecs [9];

  wb_arbiter #(.XLEN(64), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_raw    (ld_raw),
    .ld_funct3 (ld_funct3),
    .ld_off    (ld_off),
    .ld_ready  (ld_ready),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd),
    .busy      (busy)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [2:0] off, input logic [63:0] raw);
    ld_valid  = v;
    ld_rd     = rd;
    ld_funct3 = f3;
    ld_off    = off;
    ld_raw    = raw;
  endtask

  task automatic idle();
    set_alu(1'b0, 5'd0, 64'd0);
    set_ld(1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
  endtask

  task automatic check_wr(input string tag, input logic [4:0] a3, input logic [63:0] wd);
    check_eq({tag, ".we"}, 64'(rf_we), 64'd1);
    check_eq({tag, ".a3"}, 64'(rf_a3), 64'(a3));
    check_eq({tag, ".wd"}, rf_wd, wd);
  endtask

  initial begin
    vecs[0] = '{5'd7,  F3_LB,  3'd1, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{5'd8,  F3_LBU, 3'd1, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0080};
    vecs[2] = '{5'd10, F3_LWU, 3'd4, 64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001};
    vecs[3] = '{5'd10, F3_LW,  3'd4, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001};
    vecs[4] = '{5'd6,  F3_LH,  3'd3, 64'h0000_0000_ABCD_0000, 64'hFFFF_FFFF_FFFF_ABCD};
    vecs[5] = '{5'd6,  F3_LHU, 3'd6, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF};
    vecs[6] = '{5'd4,  F3_LD,  3'd5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[7] = '{5'd4,  3'b111, 3'd3, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210};
    vecs[8] = '{5'd3,  F3_LB,  3'd7, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F};

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.we",   64'(rf_we), 64'd0);
    check_eq("rst.a3",   64'(rf_a3), 64'd0);
    check_eq("rst.wd",   rf_wd, 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.ldr",  64'(ld_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
    check_eq("rst.cnt",  retire_cnt, 64'd0);
`endif
    rst = 1'b0;
    tick();

    // ALU single write, one-cycle latency, one-cycle pulse
    set_alu(1'b1, 5'd5, 64'h1234);
    settle();
    check_eq("alu.rdy", 64'(alu_ready), 64'd1);
    tick();
    check_wr("alu", 5'd5, 64'h1234);
    idle();
    tick();
    check_eq("alu.pulse", 64'(rf_we), 64'd0);

    // Load extraction table, two-cycle latency
    for (int i = 0; i < 9; i++) begin
      set_ld(1'b1, vecs[i].rd, vecs[i].f3, vecs[i].off, vecs[i].raw);
      settle();
      check_eq($sformatf("ld%0d.rdy", i), 64'(ld_ready), 64'd1);
      tick();
      idle();
      check_eq($sformatf("ld%0d.early", i), 64'(rf_we), 64'd0);
      check_eq($sformatf("ld%0d.busy", i), 64'(busy), 64'd1);
      tick();
      check_wr($sformatf("ld%0d", i), vecs[i].rd, vecs[i].exp);
    end
    tick();
    check_eq("ld.idle", 64'(rf_we), 64'd0);

    // Queue fills while ALU streams; third load and ALU stall when full
    set_alu(1'b1, 5'd1, 64'hA1);
    set_ld(1'b1, 5'd11, F3_LD, 3'd0, 64'h1111);
    settle();
    check_eq("fill.a.alurdy", 64'(alu_ready), 64'd1);
    tick();
    check_wr("fill.a", 5'd1, 64'hA1);
    set_alu(1'b1, 5'd2, 64'hA2);
    set_ld(1'b1, 5'd12, F3_LD, 3'd0, 64'h1212);
    settle();
    check_eq("fill.b.ldrdy", 64'(ld_ready), 64'd1);
    tick();
    check_wr("fill.b", 5'd2, 64'hA2);
    set_alu(1'b1, 5'd3, 64'hA3);
    set_ld(1'b1, 5'd13, F3_LD, 3'd0, 64'h1313);
    settle();
    check_eq("full.ldrdy",  64'(ld_ready), 64'd0);
    check_eq("full.alurdy", 64'(alu_ready), 64'd0);
    tick();
    check_wr("full.drain", 5'd11, 64'h1111);
    set_ld(1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
    settle();
    check_eq("full.d.alurdy", 64'(alu_ready), 64'd1);
    tick();
    check_wr("full.d", 5'd3, 64'hA3);
    idle();
    tick();
    check_wr("full.e", 5'd12, 64'h1212);
    check_eq("full.e.busy", 64'(busy), 64'd0);
    tick();
    check_eq("full.idle", 64'(rf_we), 64'd0);

    // WAW conflict on a non-head entry: load x9 must retire before ALU x9
    set_alu(1'b1, 5'd20, 64'hB20);
    set_ld(1'b1, 5'd14, F3_LD, 3'd0, 64'h1414);
    tick();
    check_wr("waw.a", 5'd20, 64'hB20);
    set_alu(1'b1, 5'd21, 64'hB21);
    set_ld(1'b1, 5'd9, F3_LD, 3'd0, 64'h0999);
    tick();
    check_wr("waw.b", 5'd21, 64'hB21);
    set_ld(1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
    set_alu(1'b1, 5'd9, 64'hA9);
    settle();
    check_eq("waw.c.alurdy", 64'(alu_ready), 64'd0);
    tick();
    check_wr("waw.c", 5'd14, 64'h1414);
    settle();
    check_eq("waw.d.alurdy", 64'(alu_ready), 64'd0);
    check_eq("waw.d.ldrdy",  64'(ld_ready), 64'd1);
    tick();
    check_wr("waw.d", 5'd9, 64'h0999);
    settle();
    check_eq("waw.e.alurdy", 64'(alu_ready), 64'd1);
    tick();
    check_wr("waw.e", 5'd9, 64'hA9);
    idle();
    tick();

    // x0 destinations: accepted, no write, nothing queued
    set_alu(1'b1, 5'd0, 64'hDEAD);
    set_ld(1'b1, 5'd0, F3_LD, 3'd0, 64'hBEEF);
    settle();
    check_eq("x0.alurdy", 64'(alu_ready), 64'd1);
    check_eq("x0.ldrdy",  64'(ld_ready), 64'd1);
    tick();
    idle();
    check_eq("x0.we",   64'(rf_we), 64'd0);
    check_eq("x0.busy", 64'(busy), 64'd0);
    tick();
    check_eq("x0.we2",  64'(rf_we), 64'd0);

    // Reset with two loads queued discards them
    set_alu(1'b1, 5'd20, 64'hC20);
    set_ld(1'b1, 5'd15, F3_LD, 3'd0, 64'h1515);
    tick();
    set_alu(1'b1, 5'd21, 64'hC21);
    set_ld(1'b1, 5'd16, F3_LD, 3'd0, 64'h1616);
    tick();
    idle();
    check_wr("pre.rst", 5'd21, 64'hC21);
    check_eq("pre.rst.ldrdy", 64'(ld_ready), 64'd0);
    rst = 1'b1;
    settle();
    check_eq("mid.rst.we",   64'(rf_we), 64'd0);
    check_eq("mid.rst.busy", 64'(busy), 64'd0);
    check_eq("mid.rst.a3",   64'(rf_a3), 64'd0);
`ifdef WB_RETIRE_CNT_EN
    check_eq("mid.rst.cnt",  retire_cnt, 64'd0);
`endif
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("post.rst%0d.we", i), 64'(rf_we), 64'd0);
      check_eq($sformatf("post.rst%0d.busy", i), 64'(busy), 64'd0);
    end

`ifdef WB_RETIRE_CNT_EN
    set_alu(1'b1, 5'd2, 64'h22);
    tick();
    idle();
    tick();
    check_eq("cnt.one", retire_cnt, 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
